// File: rtl/trig_arb_pkg.sv
// Shared types and sizing helpers for the trigger event arbiter.
package trig_arb_pkg;

    localparam int N_TRIG_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } arb_state_e;

    // Lane index width; never below one bit so the ID port always exists.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trig_event_arbiter_if.sv
// Trigger inputs and event-presentation handshake between a trigger source/consumer and the arbiter.
interface trig_event_arbiter_if import trig_arb_pkg::*; #(
    parameter int N_TRIG = N_TRIG_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    localparam int ID_W = id_w(N_TRIG);

    logic [N_TRIG-1:0] trigger;
    logic              evt_valid;
    logic [ID_W-1:0]   evt_id;
    logic              evt_ready;
    logic              ovf_clr;
    logic [N_TRIG-1:0] overflow;
    logic [CNT_W-1:0]  evt_count;

    modport slave (
        input  trigger, evt_ready, ovf_clr,
        output evt_valid, evt_id, overflow, evt_count
    );

    modport master (
        output trigger, evt_ready, ovf_clr,
        input  evt_valid, evt_id, overflow, evt_count
    );

endinterface

// File: rtl/trig_edge_det.sv
// Per-lane rising-edge detector; trig_q clears on reset so a line already high counts as an edge.
module trig_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    output logic edge_o
);

    logic trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_i;
        end
    end

    assign edge_o = trig_i & ~trig_q;

endmodule

// File: rtl/trig_event_arbiter.sv
// Collects rising edges on N_TRIG trigger lanes and presents them one at a time, round-robin.
//   state     | meaning
//   S_IDLE    | no event presented; grant next pending lane after last_grant
//   S_PRESENT | evt_id held on the bus until the consumer raises evt_ready
module trig_event_arbiter import trig_arb_pkg::*; #(
    parameter int N_TRIG = N_TRIG_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    trig_event_arbiter_if.slave  bus
);

    localparam int ID_W = id_w(N_TRIG);

    arb_state_e        state_q;
    logic [N_TRIG-1:0] pending_q, pending_d;
    logic [N_TRIG-1:0] overflow_q, overflow_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   evt_id_q;
    logic              evt_valid_q;
    logic [CNT_W-1:0]  evt_count_q;

    logic [N_TRIG-1:0] edge_w;
    logic [N_TRIG-1:0] clr_vec;
    logic [N_TRIG-1:0] ovf_set;
    logic              accept;
    logic              sel_found;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   idx_l;

    for (genvar g = 0; g < N_TRIG; g++) begin : g_lane
        trig_edge_det u_edge_det (
            .clk    (clk),
            .rst_n  (rst_n),
            .trig_i (bus.trigger[g]),
            .edge_o (edge_w[g])
        );
    end

    assign accept = (state_q == S_PRESENT) && bus.evt_ready;

    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[evt_id_q] = 1'b1;
        end
    end

    // An edge on a lane that is being accepted this cycle re-arms it instead of being dropped.
    assign ovf_set    = edge_w & pending_q & ~clr_vec;
    assign pending_d  = (pending_q & ~clr_vec) | edge_w;
    assign overflow_d = (bus.ovf_clr ? '0 : overflow_q) | ovf_set;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx_l     = '0;
        for (int off = 1; off <= N_TRIG; off++) begin
            idx_l = ID_W'((int'(last_grant_q) + off) % N_TRIG);
            if (!sel_found && pending_q[idx_l]) begin
                sel_found = 1'b1;
                sel_id    = idx_l;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            overflow_q   <= '0;
            last_grant_q <= ID_W'(N_TRIG - 1);
            evt_id_q     <= '0;
            evt_valid_q  <= 1'b0;
            evt_count_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        evt_id_q    <= sel_id;
                        evt_valid_q <= 1'b1;
                        state_q     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (bus.evt_ready) begin
                        last_grant_q <= evt_id_q;
                        evt_count_q  <= evt_count_q + CNT_W'(1);
                        evt_valid_q  <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_id    = evt_id_q;
    assign bus.overflow  = overflow_q;
    assign bus.evt_count = evt_count_q;

endmodule

// File: tb/tb_trig_event_arbiter.sv
// Directed bench for trig_event_arbiter; accepted event IDs are checked against a queue of expected lanes.
module tb_trig_event_arbiter;
    import trig_arb_pkg::*;

    localparam int N  = 4;
    // Narrow counter so the wrap can be reached within a short run.
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    trig_event_arbiter_if #(.N_TRIG(N), .CNT_W(CW)) bus ();

    trig_event_arbiter #(.N_TRIG(N), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];
    int sb_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge, well clear of both clock edges.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
            sb_exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("sb_evt_id", 32'(bus.evt_id), sb_exp);
        end
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.trigger   = '0;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.evt_valid), 0);
        chk("rst_id",    32'(bus.evt_id), 0);
        chk("rst_ovf",   32'(bus.overflow), 0);
        chk("rst_count", 32'(bus.evt_count), 0);
        cyc();
        rst_n = 1'b1;

        // single pulse, latency and one-cycle presentation
        bus.evt_ready = 1'b1;
        cyc();
        bus.trigger = 4'b0001;
        exp_q.push_back(0);
        cyc();
        bus.trigger = '0;
        @(negedge clk);
        chk("t1_valid_k", 32'(bus.evt_valid), 0);
        cyc();
        @(negedge clk);
        chk("t1_valid", 32'(bus.evt_valid), 1);
        chk("t1_id",    32'(bus.evt_id), 0);
        cyc();
        @(negedge clk);
        chk("t1_one_cycle", 32'(bus.evt_valid), 0);
        chk("t1_count",     32'(bus.evt_count), 1);

        // all four lanes at once: 0,1,2,3 at 2-cycle spacing
        cyc();
        do_reset();
        bus.trigger = 4'b1111;
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        for (int j = 0; j < 8; j++) begin
            cyc();
            if (j == 0) bus.trigger = '0;
            @(negedge clk);
            chk($sformatf("t2_valid_%0d", j), 32'(bus.evt_valid), j % 2);
        end
        cyc();
        @(negedge clk);
        chk("t2_count", 32'(bus.evt_count), 4);
        chk("t2_ovf",   32'(bus.overflow), 0);

        // backpressure: lane 2 held stable until ready
        cyc();
        bus.evt_ready = 1'b0;
        bus.trigger   = 4'b0100;
        exp_q.push_back(2);
        cyc();
        bus.trigger = '0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("t3_hold_valid_%0d", j), 32'(bus.evt_valid), 1);
            chk($sformatf("t3_hold_id_%0d", j),    32'(bus.evt_id), 2);
        end
        cyc();
        bus.evt_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("t3_valid_after", 32'(bus.evt_valid), 0);
        chk("t3_count",       32'(bus.evt_count), 5);

        // second edge on a pending lane is dropped and flagged
        cyc();
        bus.evt_ready = 1'b0;
        bus.trigger   = 4'b0010;
        exp_q.push_back(1);
        cyc();
        bus.trigger = '0;
        cyc();
        bus.trigger = 4'b0010;
        cyc();
        bus.trigger = '0;
        @(negedge clk);
        chk("t4_ovf",   32'(bus.overflow), 4'b0010);
        chk("t4_valid", 32'(bus.evt_valid), 1);
        chk("t4_id",    32'(bus.evt_id), 1);
        cyc();
        bus.evt_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("t4_valid_acc",  32'(bus.evt_valid), 0);
        chk("t4_count",      32'(bus.evt_count), 6);
        chk("t4_ovf_sticky", 32'(bus.overflow), 4'b0010);
        for (int j = 0; j < 3; j++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("t4_no_second_%0d", j), 32'(bus.evt_valid), 0);
        end
        cyc();
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        chk("t4_ovf_clr", 32'(bus.overflow), 0);

        // edge on the lane being accepted re-arms it without overflow
        cyc();
        bus.evt_ready = 1'b0;
        bus.trigger   = 4'b0001;
        exp_q.push_back(0);
        cyc();
        bus.trigger = '0;
        cyc();
        cyc();
        bus.evt_ready = 1'b1;
        bus.trigger   = 4'b0001;
        exp_q.push_back(0);
        cyc();
        bus.trigger = '0;
        @(negedge clk);
        chk("t4b_ovf",       32'(bus.overflow), 0);
        chk("t4b_valid_gap", 32'(bus.evt_valid), 0);
        cyc();
        @(negedge clk);
        chk("t4b_valid_re", 32'(bus.evt_valid), 1);
        chk("t4b_id_re",    32'(bus.evt_id), 0);
        cyc();
        @(negedge clk);
        chk("t4b_count", 32'(bus.evt_count), 8);

        // overflow set wins over a coincident clear
        cyc();
        bus.evt_ready = 1'b0;
        bus.trigger   = 4'b1000;
        exp_q.push_back(3);
        cyc();
        bus.trigger = '0;
        cyc();
        bus.trigger = 4'b1000;
        bus.ovf_clr = 1'b1;
        cyc();
        bus.trigger = '0;
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        chk("t4c_set_wins", 32'(bus.overflow), 4'b1000);
        cyc();
        bus.evt_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("t4c_count", 32'(bus.evt_count), 9);

        // counter wrap
        cyc();
        do_reset();
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            bus.trigger = 4'(1 << (i % N));
            exp_q.push_back(i % N);
            cyc();
            bus.trigger = '0;
            cyc();
            cyc();
            cyc();
        end
        @(negedge clk);
        chk("t5_count_max", 32'(bus.evt_count), (1 << CW) - 1);
        cyc();
        bus.trigger = 4'b0100;
        exp_q.push_back(2);
        cyc();
        bus.trigger = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("t5_count_wrap", 32'(bus.evt_count), 0);
        chk("t5_ovf",        32'(bus.overflow), 0);

        // asynchronous reset while presenting discards the event
        cyc();
        bus.evt_ready = 1'b0;
        bus.trigger   = 4'b1000;
        cyc();
        bus.trigger = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("t6_valid_pre", 32'(bus.evt_valid), 1);
        chk("t6_id_pre",    32'(bus.evt_id), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.evt_valid), 0);
        chk("t6_async_id",    32'(bus.evt_id), 0);
        chk("t6_async_ovf",   32'(bus.overflow), 0);
        chk("t6_async_count", 32'(bus.evt_count), 0);
        cyc();
        rst_n         = 1'b1;
        bus.evt_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("t6_no_evt_%0d", j), 32'(bus.evt_valid), 0);
        end
        chk("t6_count", 32'(bus.evt_count), 0);

        // trigger high across reset release gives exactly one event
        cyc();
        rst_n       = 1'b0;
        bus.trigger = 4'b0001;
        cyc();
        cyc();
        rst_n = 1'b1;
        exp_q.push_back(0);
        repeat (10) cyc();
        @(negedge clk);
        chk("t7_count_held", 32'(bus.evt_count), 1);
        chk("t7_valid_held", 32'(bus.evt_valid), 0);
        cyc();
        bus.trigger = '0;
        cyc();

        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/trig_event_arbiter.md
TRIG_EVENT_ARBITER -- requirements
Module: trig_event_arbiter

Interface
REQ-001 Parameter N_TRIG, default 4, number of trigger lanes (2..16).
REQ-002 Parameter CNT_W, default 16, width of the accepted-event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 trigger  input  N_TRIG  level trigger lines, synchronous to clk.
REQ-006 evt_valid  output  1  an event is presented on evt_id.
REQ-007 evt_id  output  $clog2(N_TRIG)  lane index of the presented event.
REQ-008 evt_ready  input  1  consumer accepts the event when high with evt_valid.
REQ-009 ovf_clr  input  1  one-cycle pulse that clears all overflow flags.
REQ-010 overflow  output  N_TRIG  sticky per-lane event-dropped flags.
REQ-011 evt_count  output  CNT_W  count of accepted events.

Function
REQ-012 Each lane SHALL register trigger as trig_q; edge[i] = trigger[i] & ~trig_q[i].
REQ-013 An edge sampled at clock edge k SHALL set pending[i] at edge k.
REQ-014 A held-high trigger SHALL produce exactly one edge; re-arming requires at least one low sample.
REQ-015 FSM states SHALL be IDLE and PRESENT; reset state IDLE.
REQ-016 IDLE: if any pending bit is set, select lane round-robin starting at last_grant+1 (mod N_TRIG), load evt_id, assert evt_valid, go to PRESENT; else stay.
REQ-017 PRESENT: evt_valid and evt_id SHALL hold stable while evt_ready is low.
REQ-018 PRESENT with evt_ready high: clear pending[evt_id], set last_grant = evt_id, increment evt_count, deassert evt_valid, go to IDLE.
REQ-019 Latency: a lone edge sampled at edge k SHALL give evt_valid high after edge k+1; sustained throughput is one event per 2 cycles.
REQ-020 An edge on the lane being accepted in the same cycle SHALL leave pending set (new event), with no overflow.
REQ-021 An edge on a lane whose pending bit is already set and not being cleared SHALL be dropped and set overflow[i].
REQ-022 overflow bits SHALL stay set until ovf_clr; if ovf_clr and a new overflow coincide, set wins for that lane.
REQ-023 evt_count SHALL wrap modulo 2^CNT_W (all-ones + 1 = 0).
REQ-024 Pending lanes not granted SHALL wait; no lane waits more than N_TRIG grants.

Reset
REQ-025 Reset low SHALL immediately force: evt_valid=0, evt_id=0, overflow=0, evt_count=0, pending=0, trig_q=0, FSM=IDLE, last_grant=N_TRIG-1 (lane 0 highest priority first).
REQ-026 Reset mid-PRESENT SHALL discard the presented event without counting it.
REQ-027 After reset release, a trigger already high on the first sampled edge SHALL count as a rising edge.

Structure
REQ-028 Package trig_arb_pkg SHALL hold the FSM state enum, default N_TRIG and CNT_W, and the ID-width function.
REQ-029 Sub-module trig_edge_det (one per lane: trig_q register + edge output) SHALL be instantiated N_TRIG times.
REQ-030 Round-robin selection SHALL be combinational from pending and last_grant; all outputs registered.

Verification (N_TRIG=4)
REQ-031 Reset, trigger=0001 for 1 cycle, evt_ready=1 -> evt_valid high 2 edges later with evt_id=0, one cycle only; evt_count=1.
REQ-032 trigger=1111 in one cycle, evt_ready=1 -> evt_id sequence 0,1,2,3 at 2-cycle spacing; evt_count=4; overflow=0.
REQ-033 trigger[2] pulsed, evt_ready=0 for 5 cycles -> evt_valid/evt_id=2 held stable; accepted on the first ready cycle.
REQ-034 evt_ready=0, trigger[1] pulsed twice (low between) -> overflow=0010, one event delivered; ovf_clr pulse -> overflow=0000.
REQ-035 evt_count preloaded by 65535 accepts, one more accept -> evt_count=0.
REQ-036 rst_n pulled low during PRESENT -> outputs zero asynchronously; no event delivered after release without a new edge.
